// File: rtl/mnist_pool_pkg.sv
// Shared sizing helpers and drain FSM encoding for the max-pool frame packer.
package mnist_pool_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } drain_state_t;

    function automatic int unsigned pool_dim(input int unsigned n);
        return n / 2;
    endfunction

    function automatic int unsigned calc_num_words(input int unsigned bits,
                                                   input int unsigned width);
        return (bits + width - 1) / width;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_word_serializer.sv
// Streams one full ping-pong bank as OUT_W-bit words over valid/ready, then frees it.
module frame_word_serializer
    import mnist_pool_pkg::*;
#(
    parameter int unsigned FRAME_BITS = 169,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned NUM_WORDS  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] bank0,
    input  logic [FRAME_BITS-1:0] bank1,
    input  logic [1:0]            bank_full,
    input  logic                  word_ready,
    output logic [OUT_W-1:0]      word_out,
    output logic                  word_valid,
    output logic                  word_last,
    output logic                  frame_done,
    output logic                  drain_sel
);

    localparam int unsigned IDX_W = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    drain_state_t                 state;
    logic [IDX_W-1:0]             idx;
    logic [IDX_W-1:0]             idx_nxt;
    logic [NUM_WORDS*OUT_W-1:0]   frame_pad;
    logic [OUT_W-1:0]             words [NUM_WORDS];

    // Pad the frame so the final word carries zeros above FRAME_BITS.
    always_comb begin
        frame_pad                   = '0;
        frame_pad[FRAME_BITS-1:0]   = drain_sel ? bank1 : bank0;
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_words
        assign words[g] = frame_pad[g*OUT_W +: OUT_W];
    end

    assign idx_nxt    = idx + 1'b1;
    assign frame_done = (state == StSend) && word_ready && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            idx        <= '0;
            drain_sel  <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bank_full[drain_sel]) begin
                        word_out   <= words[0];
                        word_valid <= 1'b1;
                        word_last  <= (NUM_WORDS == 1);
                        idx        <= '0;
                        state      <= StSend;
                    end
                end
                StSend: begin
                    if (word_ready) begin
                        if (idx == LAST_IDX) begin
                            word_out   <= '0;
                            word_valid <= 1'b0;
                            word_last  <= 1'b0;
                            drain_sel  <= ~drain_sel;
                            state      <= StIdle;
                        end else begin
                            idx       <= idx_nxt;
                            word_out  <= words[idx_nxt];
                            word_last <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/max_pool_frame_packer.sv
// OR-pools 2x2 binary windows, packs pooled frames into ping-pong banks and
// hands completed banks to the word serializer.
module max_pool_frame_packer
    import mnist_pool_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 26,
    parameter int unsigned IN_HEIGHT = 26,
    parameter int unsigned OUT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             pixel_0,
    input  logic             pixel_1,
    input  logic             pixel_2,
    input  logic             pixel_3,
    output logic             pooled_pixel,
    output logic             pooled_valid,
    output logic [OUT_W-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             word_last,
    output logic             frame_overflow
);

    localparam int unsigned POOL_W     = pool_dim(IN_WIDTH);
    localparam int unsigned POOL_H     = pool_dim(IN_HEIGHT);
    localparam int unsigned FRAME_BITS = POOL_W * POOL_H;
    localparam int unsigned NUM_WORDS  = calc_num_words(FRAME_BITS, OUT_W);
    localparam int unsigned CNT_W      = idx_width(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] bank0;
    logic [FRAME_BITS-1:0] bank1;
    logic [1:0]            bank_full;
    logic [1:0]            bank_full_d;
    logic                  fill_sel;
    logic [CNT_W-1:0]      pool_cnt;
    logic                  window_or;
    logic                  accept;
    logic                  frame_complete;
    logic                  frame_done;
    logic                  drain_sel;

    assign window_or      = pixel_0 | pixel_1 | pixel_2 | pixel_3;
    assign accept         = valid_in && !bank_full[fill_sel];
    assign frame_complete = accept && (pool_cnt == LAST_BIT);

    // Fill and drain always target different banks, so both updates can land together.
    always_comb begin
        bank_full_d = bank_full;
        if (frame_done) begin
            bank_full_d[drain_sel] = 1'b0;
        end
        if (frame_complete) begin
            bank_full_d[fill_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pooled_pixel   <= 1'b0;
            pooled_valid   <= 1'b0;
            frame_overflow <= 1'b0;
            bank0          <= '0;
            bank1          <= '0;
            bank_full      <= '0;
            fill_sel       <= 1'b0;
            pool_cnt       <= '0;
        end else begin
            pooled_valid <= valid_in;
            pooled_pixel <= valid_in & window_or;
            bank_full    <= bank_full_d;
            if (valid_in && bank_full[fill_sel]) begin
                frame_overflow <= 1'b1;
            end
            if (accept) begin
                if (fill_sel) begin
                    bank1[pool_cnt] <= window_or;
                end else begin
                    bank0[pool_cnt] <= window_or;
                end
                if (pool_cnt == LAST_BIT) begin
                    pool_cnt <= '0;
                    fill_sel <= ~fill_sel;
                end else begin
                    pool_cnt <= pool_cnt + 1'b1;
                end
            end
        end
    end

    frame_word_serializer #(
        .FRAME_BITS (FRAME_BITS),
        .OUT_W      (OUT_W),
        .NUM_WORDS  (NUM_WORDS)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .bank0      (bank0),
        .bank1      (bank1),
        .bank_full  (bank_full),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_last  (word_last),
        .frame_done (frame_done),
        .drain_sel  (drain_sel)
    );

endmodule

// File: tb/tb_max_pool_frame_packer.sv
// Directed bench for max_pool_frame_packer: pool table, framing, backpressure,
// overflow, overlap and reset cases against a bit-level frame model.
module tb_max_pool_frame_packer;

    localparam int FB = 169;
    localparam int NW = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        pixel_0 = 1'b0, pixel_1 = 1'b0, pixel_2 = 1'b0, pixel_3 = 1'b0;
    logic        pooled_pixel, pooled_valid;
    logic [15:0] word_out;
    logic        word_valid, word_last, frame_overflow;
    logic        word_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pv_cnt  = 0;
    int pp_ones = 0;
    int first_stamp, last_stamp, a_last;

    logic [16:0] wq [$];
    int          sq [$];

    typedef struct {
        logic [3:0] win;
        logic       exp_pix;
    } pool_vec_t;
    pool_vec_t pool_tab [7];

    max_pool_frame_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .pixel_0        (pixel_0),
        .pixel_1        (pixel_1),
        .pixel_2        (pixel_2),
        .pixel_3        (pixel_3),
        .pooled_pixel   (pooled_pixel),
        .pooled_valid   (pooled_valid),
        .word_out       (word_out),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .word_last      (word_last),
        .frame_overflow (frame_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            wq.push_back({word_last, word_out});
            sq.push_back(cyc);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (pooled_valid) begin
            pv_cnt++;
            if (pooled_pixel) pp_ones++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [FB-1:0] f, input int j);
        logic [15:0] w = '0;
        for (int i = 0; i < 16; i++) begin
            if (j * 16 + i < FB) w[i] = f[j*16+i];
        end
        return w;
    endfunction

    function automatic logic [3:0] pick_win(input int k);
        case (k % 5)
            0: return 4'b1111;
            1: return 4'b1000;
            2: return 4'b0100;
            3: return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // Drives the first n windows of frame f on consecutive cycles, valid left high.
    task automatic send_frame(input logic [FB-1:0] f, input int n);
        logic [3:0] w;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            w = f[k] ? pick_win(k) : 4'b0000;
            valid_in = 1'b1;
            {pixel_0, pixel_1, pixel_2, pixel_3} = w;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
        {pixel_0, pixel_1, pixel_2, pixel_3} = 4'b0000;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        valid_in   = 1'b0;
        word_ready = 1'b0;
        {pixel_0, pixel_1, pixel_2, pixel_3} = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        sq.delete();
    endtask

    task automatic check_drain(input logic [FB-1:0] f, input string name);
        int waited = 0;
        logic [16:0] e;
        int st;
        while (wq.size() < NW && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (wq.size() < NW) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got %0d words, expected %0d", name, wq.size(), NW);
            return;
        end
        for (int j = 0; j < NW; j++) begin
            e  = wq.pop_front();
            st = sq.pop_front();
            if (j == 0) first_stamp = st;
            if (j == NW - 1) last_stamp = st;
            check($sformatf("%s word%0d", name, j), {15'b0, e},
                  {15'b0, (j == NW - 1), exp_word(f, j)});
        end
    endtask

    logic [FB-1:0] f_ones, f_alt, f_a, f_b, f_c;

    initial begin
        pool_tab[0] = '{4'b0000, 1'b0};
        pool_tab[1] = '{4'b0100, 1'b1};
        pool_tab[2] = '{4'b0010, 1'b1};
        pool_tab[3] = '{4'b0001, 1'b1};
        pool_tab[4] = '{4'b1000, 1'b1};
        pool_tab[5] = '{4'b1111, 1'b1};
        pool_tab[6] = '{4'b0000, 1'b0};

        f_ones = '1;
        for (int k = 0; k < FB; k++) begin
            f_alt[k] = k[0];
            f_a[k]   = 1'($urandom_range(0, 1));
            f_b[k]   = 1'($urandom_range(0, 1));
            f_c[k]   = 1'($urandom_range(0, 1));
        end

        apply_reset();
        check("reset outputs", {11'b0, pooled_pixel, pooled_valid, word_out, word_valid,
              word_last, frame_overflow}, 32'h0);

        // Pool path table
        foreach (pool_tab[i]) begin
            @(negedge clk);
            valid_in = 1'b1;
            {pixel_0, pixel_1, pixel_2, pixel_3} = pool_tab[i].win;
            @(posedge clk);
            #1;
            check($sformatf("pool vec%0d", i), {30'b0, pooled_valid, pooled_pixel},
                  {30'b0, 1'b1, pool_tab[i].exp_pix});
        end
        idle();
        @(posedge clk);
        #1;
        check("pool idle", {30'b0, pooled_valid, pooled_pixel}, 32'h0);

        // All-ones frame, ready held high, first word two cycles after last window
        apply_reset();
        pv_cnt  = 0;
        pp_ones = 0;
        word_ready = 1'b1;
        send_frame(f_ones, FB);
        idle();
        check("latency t+1 no word", {31'b0, word_valid}, 32'h0);
        @(negedge clk);
        check("latency t+2 word", {31'b0, word_valid}, 32'h1);
        check("pooled pulses", pv_cnt, FB);
        check("pooled ones", pp_ones, FB);
        check_drain(f_ones, "ones");

        // Alternating frame: word 0 must be 0xAAAA
        apply_reset();
        word_ready = 1'b1;
        send_frame(f_alt, FB);
        idle();
        check_drain(f_alt, "alt");

        // Backpressure: ready 0,0,1 per word
        apply_reset();
        send_frame(f_a, FB);
        idle();
        @(negedge clk);
        for (int j = 0; j < NW; j++) begin
            logic [16:0] snap;
            word_ready = 1'b0;
            snap = {word_valid, word_out};
            @(negedge clk);
            check($sformatf("bp hold%0d a", j), {15'b0, word_valid, word_out}, {15'b0, snap});
            @(negedge clk);
            check($sformatf("bp hold%0d b", j), {15'b0, word_valid, word_out}, {15'b0, snap});
            word_ready = 1'b1;
            @(negedge clk);
        end
        word_ready = 1'b0;
        check("bp accepts", wq.size(), NW);
        check_drain(f_a, "bp");
        check("bp idle after", {31'b0, word_valid}, 32'h0);

        // Overflow: two frames stored, third window dropped
        apply_reset();
        send_frame(f_a, FB);
        send_frame(f_b, FB);
        @(negedge clk);
        check("ovf before", {31'b0, frame_overflow}, 32'h0);
        valid_in = 1'b1;
        {pixel_0, pixel_1, pixel_2, pixel_3} = 4'b1111;
        @(posedge clk);
        #1;
        check("ovf pooled", {30'b0, pooled_valid, pooled_pixel}, 32'h3);
        check("ovf set", {31'b0, frame_overflow}, 32'h1);
        idle();
        word_ready = 1'b1;
        check_drain(f_a, "ovf A");
        a_last = last_stamp;
        check_drain(f_b, "ovf B");
        check("frame gap", first_stamp - a_last, 2);
        send_frame(f_c, FB);
        idle();
        check_drain(f_c, "ovf C");
        check("ovf sticky", {31'b0, frame_overflow}, 32'h1);

        // Fill second frame while first drains
        apply_reset();
        word_ready = 1'b1;
        send_frame(f_b, FB);
        send_frame(f_c, FB);
        idle();
        check_drain(f_b, "ovl A");
        check_drain(f_c, "ovl B");
        check("ovl no ovf", {31'b0, frame_overflow}, 32'h0);

        // Reset mid-fill
        apply_reset();
        send_frame(f_ones, 80);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        #1;
        check("rst mid-fill", {11'b0, pooled_pixel, pooled_valid, word_out, word_valid,
              word_last, frame_overflow}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        sq.delete();
        word_ready = 1'b1;
        send_frame(f_a, FB);
        idle();
        check_drain(f_a, "post fill rst");

        // Reset mid-drain at word 5
        apply_reset();
        send_frame(f_ones, FB);
        idle();
        @(negedge clk);
        word_ready = 1'b1;
        repeat (5) @(negedge clk);
        word_ready = 1'b0;
        check("mid-drain accepted", wq.size(), 5);
        check("mid-drain word5", {15'b0, word_valid, word_out}, {15'b0, 1'b1, 16'hFFFF});
        #1;
        rst_n = 1'b0;
        #1;
        check("rst mid-drain", {11'b0, pooled_pixel, pooled_valid, word_out, word_valid,
              word_last, frame_overflow}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        sq.delete();
        word_ready = 1'b1;
        send_frame(f_alt, FB);
        idle();
        check_drain(f_alt, "post drain rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
